regfile_wb_queue: RTL and testbench

REGFILE_WB_QUEUE -- requirements
Module: regfile_wb_queue

---
 rtl/regfile_wb_pkg.sv | 14 +
 rtl/regfile_wb_lookup.sv | 29 ++
 rtl/regfile_wb_queue.sv | 117 +++++++++++
 tb/tb_regfile_wb_queue.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_pkg.sv
// Shared types for the register-file writeback queue.
package regfile_wb_pkg;
    localparam int ADDR_WIDTH     = 5;
    // Entry data is sized for the widest supported word; narrower builds leave the top bits zero.
    localparam int MAX_DATA_WIDTH = 64;

    typedef logic [ADDR_WIDTH-1:0] addr_t;

    typedef struct packed {
        logic                      valid;
        addr_t                     addr;
        logic [MAX_DATA_WIDTH-1:0] data;
    } entry_t;
endpackage

// File: rtl/regfile_wb_lookup.sv
// Pending-write lookup for one query port: youngest valid entry matching qaddr wins.
module regfile_wb_lookup import regfile_wb_pkg::*; #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 8
) (
    input  logic [ADDR_WIDTH-1:0]      qaddr,
    input  entry_t [DEPTH-1:0]         entries,
    input  logic [$clog2(DEPTH)-1:0]   rd_ptr,
    output logic                       hit,
    output logic [DATA_WIDTH-1:0]      data
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] idx;

    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        // Walk oldest to youngest so a younger match overrides an older one.
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if (qaddr != '0 && entries[idx].valid && entries[idx].addr == qaddr) begin
                hit  = 1'b1;
                data = entries[idx].data[DATA_WIDTH-1:0];
            end
        end
    end
endmodule

// File: rtl/regfile_wb_queue.sv
// Regfile writeback queue: circular FIFO draining up to NR_WRITE_PORTS entries per cycle, with
// pending-write lookup. Define REGFILE_WB_BYPASS_EN to forward straight into an empty, unstalled queue.
module regfile_wb_queue import regfile_wb_pkg::*; #(
    parameter int DATA_WIDTH     = 64,
    parameter int NR_WRITE_PORTS = 2,
    parameter int DEPTH          = 8,
    parameter int NR_QUERY_PORTS = 2
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic                                          wb_valid_i,
    output logic                                          wb_ready_o,
    input  logic [ADDR_WIDTH-1:0]                         wb_addr_i,
    input  logic [DATA_WIDTH-1:0]                         wb_data_i,
    output logic [NR_WRITE_PORTS-1:0][ADDR_WIDTH-1:0]     waddr_o,
    output logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0]     wdata_o,
    output logic [NR_WRITE_PORTS-1:0]                     we_o,
    input  logic                                          wr_stall_i,
    input  logic [NR_QUERY_PORTS-1:0][ADDR_WIDTH-1:0]     qaddr_i,
    output logic [NR_QUERY_PORTS-1:0]                     qhit_o,
    output logic [NR_QUERY_PORTS-1:0][DATA_WIDTH-1:0]     qdata_o,
    input  logic                                          flush_i
);
    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0]                 valid_q;
    logic [DEPTH-1:0][ADDR_WIDTH-1:0] mem_addr;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_data;
    entry_t [DEPTH-1:0]               entries;
    logic [PW-1:0]                    rd_ptr, wr_ptr;
    logic [PW:0]                      count, n_drain;
    logic                             accept, bypass, alloc;

    assign wb_ready_o = !rst_i && (count < (PW+1)'(DEPTH)) && !flush_i;
    assign accept     = wb_valid_i && wb_ready_o;
`ifdef REGFILE_WB_BYPASS_EN
    assign bypass = accept && (wb_addr_i != '0) && (count == '0) && !wr_stall_i;
`else
    assign bypass = 1'b0;
`endif
    // x0 writes are acknowledged but never stored.
    assign alloc = accept && (wb_addr_i != '0) && !bypass;

    always_comb begin
        n_drain = '0;
        if (!wr_stall_i && !flush_i)
            n_drain = (count < (PW+1)'(NR_WRITE_PORTS)) ? count : (PW+1)'(NR_WRITE_PORTS);
    end

    // Oldest entry on port 0 so the highest port carries the youngest write.
    always_comb begin
        we_o    = '0;
        waddr_o = '0;
        wdata_o = '0;
        for (int k = 0; k < NR_WRITE_PORTS; k++) begin
            if ((PW+1)'(k) < n_drain) begin
                we_o[k]    = 1'b1;
                waddr_o[k] = mem_addr[rd_ptr + PW'(k)];
                wdata_o[k] = mem_data[rd_ptr + PW'(k)];
            end
        end
`ifdef REGFILE_WB_BYPASS_EN
        if (bypass) begin
            we_o[0]    = 1'b1;
            waddr_o[0] = wb_addr_i;
            wdata_o[0] = wb_data_i;
        end
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            valid_q <= '0;
        end else if (flush_i) begin
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            valid_q <= '0;
        end else begin
            for (int k = 0; k < NR_WRITE_PORTS; k++)
                if ((PW+1)'(k) < n_drain) valid_q[rd_ptr + PW'(k)] <= 1'b0;
            if (alloc) valid_q[wr_ptr] <= 1'b1;
            rd_ptr <= rd_ptr + n_drain[PW-1:0];
            wr_ptr <= wr_ptr + PW'(alloc);
            count  <= count + (PW+1)'(alloc) - n_drain;
        end
    end

    // Payload storage carries no reset; valid_q alone defines occupancy.
    always_ff @(posedge clk_i) begin
        if (alloc && !flush_i) begin
            mem_addr[wr_ptr] <= wb_addr_i;
            mem_data[wr_ptr] <= wb_data_i;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            entries[i] = '{valid: valid_q[i], addr: mem_addr[i], data: MAX_DATA_WIDTH'(mem_data[i])};
    end

    for (genvar q = 0; q < NR_QUERY_PORTS; q++) begin : g_lookup
        regfile_wb_lookup #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_lookup (
            .qaddr   (qaddr_i[q]),
            .entries (entries),
            .rd_ptr  (rd_ptr),
            .hit     (qhit_o[q]),
            .data    (qdata_o[q])
        );
    end
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Randomized + directed bench for regfile_wb_queue against a queue-based reference model.
module tb_regfile_wb_queue;
    localparam int DW = 64, NW = 2, DEPTH = 8, NQ = 2;

    logic clk = 1'b0, rst = 1'b1;
    logic wb_valid = 1'b0, wb_ready, wr_stall = 1'b0, flush = 1'b0;
    logic [4:0] wb_addr = '0;
    logic [DW-1:0] wb_data = '0;
    logic [NW-1:0][4:0] waddr;
    logic [NW-1:0][DW-1:0] wdata;
    logic [NW-1:0] we;
    logic [NQ-1:0][4:0] qaddr = '0;
    logic [NQ-1:0] qhit;
    logic [NQ-1:0][DW-1:0] qdata;

    int n_chk = 0, n_fail = 0;

    typedef struct {
        logic [4:0]    a;
        logic [DW-1:0] d;
    } ref_t;
    ref_t mq[$];

    regfile_wb_queue #(.DATA_WIDTH(DW), .NR_WRITE_PORTS(NW), .DEPTH(DEPTH), .NR_QUERY_PORTS(NQ)) dut (
        .clk_i(clk), .rst_i(rst), .wb_valid_i(wb_valid), .wb_ready_o(wb_ready),
        .wb_addr_i(wb_addr), .wb_data_i(wb_data), .waddr_o(waddr), .wdata_o(wdata), .we_o(we),
        .wr_stall_i(wr_stall), .qaddr_i(qaddr), .qhit_o(qhit), .qdata_o(qdata), .flush_i(flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, compare every output against the model, then advance the model.
    task automatic step(input logic v, input logic [4:0] a, input logic [DW-1:0] d,
                        input logic st, input logic fl, input logic [4:0] qa0, input logic [4:0] qa1);
        int n;
        logic rdy, byp, hit;
        logic [NW-1:0] ewe;
        logic [4:0] ea [NW];
        logic [DW-1:0] ed [NW];
        logic [4:0] qa;
        logic [DW-1:0] hd;
        ref_t e;
        @(negedge clk);
        wb_valid = v; wb_addr = a; wb_data = d; wr_stall = st; flush = fl;
        qaddr[0] = qa0; qaddr[1] = qa1;
        #1;
        rdy = (mq.size() < DEPTH) && !fl;
        n   = (st || fl) ? 0 : ((mq.size() < NW) ? mq.size() : NW);
        ewe = '0;
        for (int k = 0; k < NW; k++) begin
            ea[k] = '0; ed[k] = '0;
            if (k < n) begin ewe[k] = 1'b1; ea[k] = mq[k].a; ed[k] = mq[k].d; end
        end
        byp = 1'b0;
`ifdef REGFILE_WB_BYPASS_EN
        if (v && rdy && a != 0 && mq.size() == 0 && !st) begin
            byp = 1'b1; ewe[0] = 1'b1; ea[0] = a; ed[0] = d;
        end
`endif
        chk("ready", wb_ready, rdy);
        chk("we", we, ewe);
        for (int k = 0; k < NW; k++) begin
            chk($sformatf("waddr%0d", k), waddr[k], ea[k]);
            chk($sformatf("wdata%0d", k), wdata[k], ed[k]);
        end
        for (int j = 0; j < NQ; j++) begin
            qa = (j == 0) ? qa0 : qa1;
            hit = 1'b0; hd = '0;
            if (qa != 0)
                foreach (mq[i]) if (mq[i].a == qa) begin hit = 1'b1; hd = mq[i].d; end
            chk($sformatf("qhit%0d", j), qhit[j], hit);
            chk($sformatf("qdata%0d", j), qdata[j], hd);
        end
        if (fl) mq.delete();
        else begin
            for (int k = 0; k < n; k++) void'(mq.pop_front());
            if (v && rdy && a != 0 && !byp) begin e.a = a; e.d = d; mq.push_back(e); end
        end
    endtask

    task automatic idle();
        step(1'b0, 5'd0, '0, 1'b0, 1'b0, 5'd0, 5'd0);
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1; wb_valid = 1'b0; flush = 1'b0; wr_stall = 1'b0;
        #1;
        chk("rst_we", we, '0);
        chk("rst_ready", wb_ready, 1'b0);
        chk("rst_qhit", qhit, '0);
        mq.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        pulse_rst();
        idle();
        chk("ready_after_rst", wb_ready, 1'b1);

        // x5=A then x5=B back to back: program order on the write ports
        step(1'b1, 5'd5, 64'hA, 1'b0, 1'b0, 5'd5, 5'd0);
        step(1'b1, 5'd5, 64'hB, 1'b0, 1'b0, 5'd5, 5'd0);
        idle(); idle();

        // fill under stall, 9th refused, then drain two per cycle
        for (int i = 0; i < 8; i++) step(1'b1, 5'(i + 1), 64'h100 + 64'(i), 1'b1, 1'b0, 5'd3, 5'd8);
        step(1'b1, 5'd9, 64'h999, 1'b1, 1'b0, 5'd9, 5'd1);
        chk("full_ready", wb_ready, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 5'd0, '0, 1'b0, 1'b0, 5'd2, 5'd7);
            chk("drain_two", we, 2'b11);
        end
        idle();
        chk("drained_we", we, '0);

        // x0 write is swallowed
        step(1'b1, 5'd0, 64'hFF, 1'b0, 1'b0, 5'd0, 5'd0);
        idle();
        chk("x0_we", we, '0);
        idle();
        chk("x0_we2", we, '0);

        // youngest match wins
        step(1'b1, 5'd7, 64'd1, 1'b1, 1'b0, 5'd0, 5'd0);
        step(1'b1, 5'd7, 64'd2, 1'b1, 1'b0, 5'd0, 5'd0);
        step(1'b0, 5'd0, '0, 1'b1, 1'b0, 5'd7, 5'd0);
        chk("q7_hit", qhit[0], 1'b1);
        chk("q7_data", qdata[0], 64'd2);
        chk("q0_hit", qhit[1], 1'b0);
        idle(); idle();

        // flush with three entries, then reset mid-drain
        for (int i = 0; i < 3; i++) step(1'b1, 5'(10 + i), 64'h40 + 64'(i), 1'b1, 1'b0, 5'd10, 5'd0);
        step(1'b1, 5'd4, 64'h44, 1'b0, 1'b1, 5'd11, 5'd0);
        chk("flush_we", we, '0);
        chk("flush_ready", wb_ready, 1'b0);
        idle();
        chk("post_flush_we", we, '0);
        for (int i = 0; i < 6; i++) step(1'b1, 5'(20 + i), 64'h200 + 64'(i), 1'b1, 1'b0, 5'd20, 5'd0);
        step(1'b0, 5'd0, '0, 1'b0, 1'b0, 5'd22, 5'd25);
        chk("mid_drain_we", we, 2'b11);
        pulse_rst();
        idle();
        chk("post_rst_we", we, '0);

`ifdef REGFILE_WB_BYPASS_EN
        step(1'b1, 5'd3, 64'h55, 1'b0, 1'b0, 5'd0, 5'd0);
        chk("bypass_we0", we[0], 1'b1);
        chk("bypass_waddr0", waddr[0], 5'd3);
        chk("bypass_wdata0", wdata[0], 64'h55);
        idle();
`endif

        for (int c = 0; c < 400; c++) begin
            step($urandom_range(0, 3) != 0,
                 ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7)),
                 {$urandom, $urandom},
                 $urandom_range(0, 9) < 3,
                 $urandom_range(0, 19) == 0,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        repeat (6) idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
